// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT front end: parameter defaults, the
// feeder read-FSM encoding and the twiddle exponent helper.
package ntt_pkg;

    localparam int N_DEF      = 17;
    localparam int PTS_DEF    = 16;
    localparam int LOGPTS_DEF = 4;
    localparam int NUM_LANES  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } rd_state_e;

    // (k*j) mod PTS built from shift-adds; k only ever spans the four lanes
    function automatic logic [LOGPTS_DEF-1:0] tw_exp(input logic [1:0] k,
                                                     input logic [LOGPTS_DEF-1:0] j);
        logic [LOGPTS_DEF-1:0] r;
        r = '0;
        if (k[0]) r = r + j;
        if (k[1]) r = r + {j[LOGPTS_DEF-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// Two PTS-word banks with a single write port and a four-lane read port
// that fetches words grp, grp+S, grp+2S, grp+3S of the selected bank.
module pingpong_bank
    import ntt_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PTS    = PTS_DEF,
    parameter int LOGPTS = LOGPTS_DEF
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic                            wr_bank,
    input  logic [LOGPTS-1:0]               wr_idx,
    input  logic [N-1:0]                    wr_data,
    input  logic                            rd_bank,
    input  logic [LOGPTS-1:0]               rd_grp,
    output logic [NUM_LANES-1:0][N-1:0]     rd_data
);

    localparam int S = PTS / NUM_LANES;

    logic [N-1:0] mem [2][PTS];

    // Contents are deliberately left unreset; full flags gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam logic [LOGPTS-1:0] OFS = LOGPTS'(l * S);
        logic [LOGPTS-1:0] addr;
        assign addr       = rd_grp + OFS;
        assign rd_data[l] = mem[rd_bank][addr];
    end

endmodule

// File: rtl/radix4_stage_feeder.sv
// Ping-pong block buffer feeding radix-4 DIF first-stage butterfly groups:
// serial coefficients in, four stride-S operands plus twiddle exponents out.
module radix4_stage_feeder
    import ntt_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PTS    = PTS_DEF,
    parameter int LOGPTS = LOGPTS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      a0,
    output logic [N-1:0]      a1,
    output logic [N-1:0]      a2,
    output logic [N-1:0]      a3,
    output logic [LOGPTS-1:0] e0,
    output logic [LOGPTS-1:0] e1,
    output logic [LOGPTS-1:0] e2,
    output logic [LOGPTS-1:0] e3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int S = PTS / NUM_LANES;
    localparam logic [LOGPTS-1:0] IDX_LAST = LOGPTS'(PTS - 1);
    localparam logic [LOGPTS-1:0] GRP_LAST = LOGPTS'(S - 1);
    localparam logic [LOGPTS-1:0] ONE      = LOGPTS'(1);

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, rd_bank_q;
    logic [LOGPTS-1:0] wr_idx_q, grp_q;
    rd_state_e         state_q, state_d;

    logic wr_fire, wr_done, rd_fire, rd_done;
    logic [NUM_LANES-1:0][N-1:0] lane_data;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_idx_q == IDX_LAST);
    assign rd_fire  = out_valid && out_ready;
    assign rd_done  = rd_fire && (grp_q == GRP_LAST);

    // Fill and release always target different banks, so both may land together.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) state_d = ISSUE;
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready && (grp_q == GRP_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            grp_q     <= '0;
            state_q   <= IDLE;
        end else begin
            full_q  <= full_d;
            state_q <= state_d;
            if (wr_fire) begin
                wr_idx_q <= wr_done ? '0 : wr_idx_q + ONE;
                if (wr_done) wr_bank_q <= ~wr_bank_q;
            end
            if (rd_fire) begin
                grp_q <= rd_done ? '0 : grp_q + ONE;
                if (rd_done) rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    pingpong_bank #(
        .N      (N),
        .PTS    (PTS),
        .LOGPTS (LOGPTS)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank_q),
        .wr_idx  (wr_idx_q),
        .wr_data (in_data),
        .rd_bank (rd_bank_q),
        .rd_grp  (grp_q),
        .rd_data (lane_data)
    );

    assign a0 = lane_data[0];
    assign a1 = lane_data[1];
    assign a2 = lane_data[2];
    assign a3 = lane_data[3];

    // grp < S keeps 3*grp below PTS except where truncation gives the wanted mod
    assign e0 = '0;
    assign e1 = grp_q;
    assign e2 = {grp_q[LOGPTS-2:0], 1'b0};
    assign e3 = e1 + e2;

    assign out_last = out_valid && (grp_q == GRP_LAST);

    a_issue_has_data: assert property (@(posedge clk) disable iff (rst)
        (state_q == ISSUE) |-> full_q[rd_bank_q]);

    a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(grp_q) && $stable(rd_bank_q)));

endmodule

// File: tb/tb_radix4_stage_feeder.sv
// Directed and randomized checks of the radix-4 stage feeder with PTS=16, N=17.
module tb_radix4_stage_feeder;

    localparam int N = 17;
    localparam int PTS = 16;
    localparam int LOGPTS = 4;
    localparam int W = 4 * N + 4 * LOGPTS + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N-1:0]      a0, a1, a2, a3;
    logic [LOGPTS-1:0] e0, e1, e2, e3;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] words [0:1599];

    int ta [4][4] = '{'{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}, '{4, 8, 12, 16}};
    int te [4][4] = '{'{0, 0, 0, 0}, '{0, 1, 2, 3}, '{0, 2, 4, 6}, '{0, 3, 6, 9}};

    always #5 clk = ~clk;

    radix4_stage_feeder #(.N(N), .PTS(PTS), .LOGPTS(LOGPTS)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .e0(e0), .e1(e1), .e2(e2), .e3(e3),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    function automatic logic [W-1:0] obs();
        return {a0, a1, a2, a3, e0, e1, e2, e3, out_last};
    endfunction

    function automatic logic [W-1:0] table_grp(int j);
        return {17'(ta[j][0]), 17'(ta[j][1]), 17'(ta[j][2]), 17'(ta[j][3]),
                4'(te[j][0]), 4'(te[j][1]), 4'(te[j][2]), 4'(te[j][3]), j == 3};
    endfunction

    function automatic logic [N-1:0] b2b_val(int w);
        return 17'(((w / 16) + 1) * 256 + (w % 16));
    endfunction

    function automatic logic [N-1:0] strm_val(int w);
        return 17'(((w / 16) + 5) * 4096 + (w % 16));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    endtask

    task automatic test_single_block();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 17'(i + 1); in_valid = 1'b1;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL single_fill bad_cycles=%0d want=0", bad); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early out_valid=%b want=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency out_valid=%b want=1", out_valid); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || obs() !== table_grp(j)) begin
                failures++; $display("FAIL single_grp%0d got=%h want=%h v=%b", j, obs(), table_grp(j), out_valid);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_end out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = 17'(i + 1); in_valid = 1'b1;
            if (in_ready !== 1'b1) bad++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_fill bad_cycles=%0d want=0", bad); end
        tick();
        checks++; if (out_valid !== 1'b1 || obs() !== table_grp(0)) begin failures++; $display("FAIL bp_grp0 got=%h want=%h", obs(), table_grp(0)); end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || obs() !== table_grp(2)) begin
                failures++; $display("FAIL bp_hold%0d got=%h want=%h v=%b", c, obs(), table_grp(2), out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || obs() !== table_grp(2)) begin failures++; $display("FAIL bp_release got=%h want=%h", obs(), table_grp(2)); end
        tick();
        checks++; if (out_valid !== 1'b1 || obs() !== table_grp(3)) begin failures++; $display("FAIL bp_grp3 got=%h want=%h", obs(), table_grp(3)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_end out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int wcnt, rcnt, cyc, b, g;
        logic acc;
        logic [W-1:0] exp_v;
        wcnt = 0; rcnt = 0; cyc = 0;
        out_ready = 1'b0;
        while (wcnt < 32 && cyc < 200) begin
            in_data = b2b_val(wcnt); in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) wcnt++;
            cyc++;
        end
        checks++; if (wcnt != 32) begin failures++; $display("FAIL b2b_fill accepted=%0d want=32", wcnt); end
        in_data = b2b_val(32);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full in_ready=%b want=0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || a0 !== 17'h100) begin
                failures++; $display("FAIL b2b_stall%0d in_ready=%b out_valid=%b a0=%h want 0/1/100", c, in_ready, out_valid, a0);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_v = {b2b_val(j), b2b_val(j + 4), b2b_val(j + 8), b2b_val(j + 12),
                     4'd0, 4'(j), 4'(2 * j), 4'(3 * j), j == 3};
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs() !== exp_v) begin
                failures++; $display("FAIL b2b_drain%0d got=%h want=%h in_ready=%b", j, obs(), exp_v, in_ready);
            end
            tick();
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release in_ready=%b want=1", in_ready); end
        rcnt = 4;
        cyc = 0;
        while ((rcnt < 12 || wcnt < 48) && cyc < 400) begin
            if (wcnt < 48) begin in_valid = 1'b1; in_data = b2b_val(wcnt); end
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                b = rcnt / 4; g = rcnt % 4;
                exp_v = {b2b_val(b * 16 + g), b2b_val(b * 16 + g + 4), b2b_val(b * 16 + g + 8),
                         b2b_val(b * 16 + g + 12), 4'd0, 4'(g), 4'(2 * g), 4'(3 * g), g == 3};
                checks++;
                if (obs() !== exp_v) begin failures++; $display("FAIL b2b_grp%0d got=%h want=%h", rcnt, obs(), exp_v); end
                rcnt++;
            end
            tick();
            if (acc) wcnt++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (rcnt != 12 || wcnt != 48) begin failures++; $display("FAIL b2b_done groups=%0d words=%0d want 12/48", rcnt, wcnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_stream();
        int wcnt, rcnt, cyc, b, g;
        logic acc;
        logic [W-1:0] exp_v;
        do_reset();
        wcnt = 0; rcnt = 0; cyc = 0;
        out_ready = 1'b1;
        while ((wcnt < 64 || rcnt < 16) && cyc < 300) begin
            if (wcnt < 64) begin
                in_valid = 1'b1; in_data = strm_val(wcnt);
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready word=%0d got=%b want=1", wcnt, in_ready); end
            end else in_valid = 1'b0;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                b = rcnt / 4; g = rcnt % 4;
                exp_v = {strm_val(b * 16 + g), strm_val(b * 16 + g + 4), strm_val(b * 16 + g + 8),
                         strm_val(b * 16 + g + 12), 4'd0, 4'(g), 4'(2 * g), 4'(3 * g), g == 3};
                checks++;
                if (obs() !== exp_v) begin failures++; $display("FAIL stream_grp%0d got=%h want=%h", rcnt, obs(), exp_v); end
                rcnt++;
            end
            tick();
            if (acc) wcnt++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (rcnt != 16 || wcnt != 64) begin failures++; $display("FAIL stream_done groups=%0d words=%0d want 16/64", rcnt, wcnt); end
    endtask

    task automatic test_reset_partial();
        logic [W-1:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 17'(12'hAA0 + i); in_valid = 1'b1;
            tick();
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstp_after in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        for (int i = 0; i < 16; i++) begin
            in_data = 17'h1FFFF; in_valid = 1'b1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstp_early word=%0d out_valid=%b want=0", i, out_valid); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            exp_v = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 4'd0, 4'(j), 4'(2 * j), 4'(3 * j), j == 3};
            checks++;
            if (out_valid !== 1'b1 || obs() !== exp_v) begin failures++; $display("FAIL rstp_grp%0d got=%h want=%h v=%b", j, obs(), exp_v, out_valid); end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstp_extra%0d out_valid=%b want=0", c, out_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        int wcnt, rcnt, cyc, b, g;
        logic wacc, hold;
        logic [W-1:0] exp_v, prev;
        do_reset();
        wcnt = 0; rcnt = 0; cyc = 0; hold = 1'b0; prev = '0;
        while (rcnt < 400 && cyc < 20000) begin
            in_valid  = (wcnt < 1600) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 17'($urandom_range(0, 17'h1FFFF));
            out_ready = 1'($urandom_range(0, 1));
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || obs() !== prev) begin
                    failures++; $display("FAIL rand_hold cyc=%0d got=%h want=%h v=%b", cyc, obs(), prev, out_valid);
                end
            end
            wacc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                b = rcnt / 4; g = rcnt % 4;
                exp_v = {words[b * 16 + g], words[b * 16 + g + 4], words[b * 16 + g + 8],
                         words[b * 16 + g + 12], 4'd0, 4'(g), 4'(2 * g), 4'(3 * g), g == 3};
                checks++;
                if (obs() !== exp_v) begin failures++; $display("FAIL rand_grp%0d got=%h want=%h", rcnt, obs(), exp_v); end
                rcnt++;
            end
            hold = out_valid && !out_ready;
            prev = obs();
            if (wacc) begin words[wcnt] = in_data; wcnt++; end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcnt != 400 || wcnt != 1600) begin failures++; $display("FAIL rand_done groups=%0d words=%0d want 400/1600", rcnt, wcnt); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_idle out_valid=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_stream();
        test_reset_partial();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/radix4_stage_feeder.md
# radix4_stage_feeder

Ping-pong block buffer directly upstream of `radix_4_dif_ntt`. Accepts a serial coefficient stream (one word per handshake), stores one PTS-point block per bank, and issues radix-4 DIF first-stage butterfly groups: four stride-S operands plus the twiddle exponent for each lane. Downstream, a twiddle ROM maps the exponents to `tf0..tf3`. The butterfly consumes the operands combinationally.

## Interface
Parameters:
- `N`, 17, coefficient width in bits (equals butterfly LOGQ)
- `PTS`, 16, points per block; a power of 4, at least 4
- `LOGPTS`, 4, log2(PTS); width of word index and twiddle exponent

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  N  coefficient, natural order within a block
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  feeder accepts `in_data` this cycle
- `a0`..`a3`  out  N each  butterfly operands
- `e0`..`e3`  out  LOGPTS each  twiddle exponents for lanes 0..3
- `out_valid`  out  1  a0..a3/e0..e3 valid
- `out_ready`  in  1  consumer takes the group this cycle
- `out_last`  out  1  high with the final group of a block

## Operation
- S = PTS/4. Block words are x[0..PTS-1]. Group j (0..S-1) has ak = x[j + k·S] and ek = (k·j) mod PTS, for k = 0..3. Groups are issued in order j = 0,1,…,S-1.
- Two banks of PTS×N flops. Each bank has a `full` flag. The write pointer is (`wr_bank`, `wr_idx`); the read pointer is (`rd_bank`, `grp`).
- Write side:
  - `in_ready = !full[wr_bank]`.
  - On an `in_valid && in_ready` cycle, store to bank[wr_bank][wr_idx] and increment `wr_idx`.
  - When `wr_idx` = PTS-1 is accepted: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_idx` to 0.
- Read FSM states: IDLE and ISSUE.
  - IDLE → ISSUE when `full[rd_bank]`. `grp` is 0 on entry.
  - In ISSUE, `out_valid` = 1. On `out_valid && out_ready`, `grp` increments.
  - When the group with `grp` = S-1 is accepted: clear `full[rd_bank]`, toggle `rd_bank`, go to IDLE.
- Outputs are read from the bank array combinationally, indexed by the registered `rd_bank`/`grp`. They hold stable while `out_valid && !out_ready`.
- `out_last = out_valid && grp == S-1`.
- Data passes through unmodified. No modular reduction here; the upstream source guarantees values < Q.
- Simultaneous write-fill and read-release on different banks: both take effect in the same edge.
- Release of a bank clears its `full` flag at the edge. `in_ready` for that bank rises the following cycle; there is no same-cycle bypass.
- Reset: `full` = 0, `wr_bank` = `rd_bank` = 0, `wr_idx` = `grp` = 0, FSM = IDLE. A partially written or partially issued block is discarded. Bank contents are not cleared.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_last` = 0. `a*` and `e*` are don't-care while `out_valid` = 0; the bench must not check them.
- Latency: the last word of a block is accepted at edge T. `full` is set at T, FSM enters ISSUE at T+1, and `out_valid` is high in cycle T+1 onwards.
- Throughput:
  - One group per cycle with `out_ready` held high, so S cycles per block.
  - The write side needs PTS cycles per block, so the stream is never throttled by the read side in steady state.
- When both banks are full, `in_ready` = 0 until release + 1 cycle.
- `out_valid` never drops without a handshake.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.

## Structure
- Shared package `ntt_pkg`:
  - Parameter defaults N, PTS, LOGPTS.
  - Read-FSM state enum {IDLE, ISSUE}.
  - Function `tw_exp(k, j)` returning (k·j) mod PTS.
- One natural sub-module: `pingpong_bank`. It holds 2×PTS×N storage with one write port and a four-lane stride-S read port.
- The top level holds the counters, flags and FSM.
- Exponent generation uses adders (e1 += j, e2 = 2·e1, e3 = e1 + e2) or `tw_exp`. No multipliers.

## Test plan
- Reset, then PTS=16 block x[i] = i+1 with `out_ready` = 1. Outputs must be:
  - j=0: a=(1,5,9,13), e=(0,0,0,0)
  - j=1: a=(2,6,10,14), e=(0,1,2,3)
  - j=3: a=(4,8,12,16), e=(0,3,6,9), `out_last` = 1
  - `out_valid` first high the cycle after the 16th accept.
- Backpressure: `out_ready` = 0 for 5 cycles during j=2. a=(3,7,11,15) and e=(0,2,4,6) must hold steady, and `grp` must not advance.
- Three back-to-back blocks with `out_ready` = 0:
  - `in_ready` drops after the 32nd accept.
  - Asserting `out_ready` drains block 1.
  - `in_ready` rises exactly one cycle after the j=3 handshake.
  - Block 3 is issued with its own data.
- Continuous stream of 4 blocks with `out_ready` = 1: `in_ready` stays 1 throughout; groups for each block appear in order with correct `out_last`.
- `rst` asserted after 7 words of a block, then a fresh block of 0x1FFFF (all-ones, N=17): no output from the partial data; the new block issues a0..a3 = 0x1FFFF.
- Random `in_valid`/`out_ready` with a scoreboard against the reference equations for 100 blocks. Checks: no loss, no duplication, exponent correctness.
